// File: rtl/toggle_rate_sequencer.sv
// toggle_rate_sequencer
//
// Generates the 7-bit TOGGLE_RATE that feeds every DSP column. A start request
// captures the run settings, the rate ramps from 0 to the target in fixed
// increments, holds the plateau for a programmed number of cycles, then ramps
// back down to 0. Every step is at most the programmed increment and lasts the
// programmed dwell, which bounds supply di/dt.
//
// Ports:
//   clk          - clock
//   rst          - asynchronous active-high reset
//   start        - level-sampled start request, honoured in IDLE only
//   abort        - graceful early ramp-down request (UP/HOLD only)
//   target_rate  - plateau rate, captured at start (clamped to MAX_RATE)
//   step         - increment/decrement per step, captured at start (0 -> 1)
//   dwell_cycles - cycles per step, captured at start (0 -> 1)
//   hold_cycles  - plateau length in cycles, captured at start (0 -> 1)
//   TOGGLE_RATE  - registered rate output
//   busy         - high in any state other than IDLE
//   done         - one-cycle pulse on return to IDLE
module toggle_rate_sequencer #(
  parameter int unsigned MAX_RATE = 100,
  parameter int unsigned DWELL_W  = 16,
  parameter int unsigned HOLD_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [6:0]         target_rate,
  input  logic [6:0]         step,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [HOLD_W-1:0]  hold_cycles,
  output logic [6:0]         TOGGLE_RATE,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CntW    = (DWELL_W > HOLD_W) ? DWELL_W : HOLD_W;
  localparam logic [6:0]  MaxRate = 7'(MAX_RATE);

  typedef enum logic [1:0] {StIdle, StUp, StHold, StDown} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [6:0]         rate_q, rate_d;
  logic [6:0]         tgt_q, tgt_d;
  logic [6:0]         stp_q, stp_d;
  logic [DWELL_W-1:0] dw_q, dw_d;
  logic [HOLD_W-1:0]  hd_q, hd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CntW-1:0] dw_last, hd_last;
  logic [7:0]      up_sum;
  logic [6:0]      up_next, down_next, tgt_in;
  logic            dwell_end;

  assign dw_last   = CntW'(dw_q) - CntW'(1);
  assign hd_last   = CntW'(hd_q) - CntW'(1);
  assign dwell_end = (cnt_q == dw_last);

  // 8-bit sum so rate + step can never wrap before the clamp.
  assign up_sum    = {1'b0, rate_q} + {1'b0, stp_q};
  assign up_next   = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[6:0];
  assign down_next = (rate_q > stp_q) ? (rate_q - stp_q) : 7'd0;
  assign tgt_in    = (target_rate > MaxRate) ? MaxRate : target_rate;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    tgt_d   = tgt_q;
    stp_d   = stp_q;
    dw_d    = dw_q;
    hd_d    = hd_q;
    busy_d  = 1'b1;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        rate_d = 7'd0;
        cnt_d  = '0;
        busy_d = 1'b0;
        // abort wins over start in IDLE
        if (start && !abort) begin
          tgt_d   = tgt_in;
          stp_d   = (step == 7'd0) ? 7'd1 : step;
          dw_d    = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
          hd_d    = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
          busy_d  = 1'b1;
          state_d = (tgt_in == 7'd0) ? StHold : StUp;
        end
      end

      StUp, StHold: begin
        if (abort) begin
          cnt_d = '0;
          if (rate_q == 7'd0) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StDown;
          end
        end else if (state_q == StUp) begin
          if (dwell_end) begin
            rate_d = up_next;
            cnt_d  = '0;
            if (up_next == tgt_q) state_d = StHold;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          if (cnt_q == hd_last) begin
            cnt_d = '0;
            // A zero-target run has nothing to ramp down, so it ends here.
            if (rate_q == 7'd0) begin
              state_d = StIdle;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = StDown;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StDown: begin
        if (dwell_end) begin
          rate_d = down_next;
          cnt_d  = '0;
          if (down_next == 7'd0) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        rate_d  = 7'd0;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rate_q  <= 7'd0;
      tgt_q   <= 7'd0;
      stp_q   <= 7'd0;
      dw_q    <= '0;
      hd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      tgt_q   <= tgt_d;
      stp_q   <= stp_d;
      dw_q    <= dw_d;
      hd_q    <= hd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TOGGLE_RATE = rate_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_toggle_rate_sequencer.sv
// Self-checking bench for toggle_rate_sequencer: a table of whole-run vectors,
// hand-written corner sequences, and randomized runs compared cycle by cycle
// against an arithmetic model of the ramp/hold/ramp profile.
module tb_toggle_rate_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [6:0]  target_rate;
  logic [6:0]  step;
  logic [15:0] dwell_cycles;
  logic [31:0] hold_cycles;
  logic [6:0]  TOGGLE_RATE;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  toggle_rate_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .target_rate  (target_rate),
    .step         (step),
    .dwell_cycles (dwell_cycles),
    .hold_cycles  (hold_cycles),
    .TOGGLE_RATE  (TOGGLE_RATE),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tgt;
    int stp;
    int dw;
    int hd;
    int exp_peak;
    int exp_cycles;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rate after edge t of an unaborted run (edge 0 samples start).
  function automatic int norm_rate(input int t, input int T, input int S, input int D,
                                   input int H, input int U);
    int v;
    if (t < U) begin
      v = (t / D) * S;
      return (v > T) ? T : v;
    end else if (t < U + H) begin
      return T;
    end
    v = T - ((t - U - H) / D) * S;
    return (v < 0) ? 0 : v;
  endfunction

  // One run checked every cycle against the model. abort_at: edge that samples an
  // abort (0 = none); abort_dn pulses abort during the ramp-down; start_hold keeps
  // start high while busy; extra = idle cycles checked after done.
  task automatic run_one(input int tgt, input int stp, input int dw, input int hd,
                         input int abort_at, input bit abort_dn, input bit start_hold,
                         input int extra, input string tag);
    int T, S, D, H, U, fin, r, a_dn, er, k;
    T    = (tgt > 100) ? 100 : tgt;
    S    = (stp == 0) ? 1 : stp;
    D    = (dw == 0) ? 1 : dw;
    H    = (hd == 0) ? 1 : hd;
    U    = ((T + S - 1) / S) * D;
    fin  = 2 * U + H;
    a_dn = -1;
    r    = 0;
    if (abort_at >= 1 && abort_at <= U + H) begin
      r   = norm_rate(abort_at - 1, T, S, D, H, U);
      fin = (r == 0) ? abort_at : abort_at + ((r + S - 1) / S) * D;
    end else begin
      abort_at = -1;
      if (abort_dn && U > 0) a_dn = U + H + 1;
    end
    @(negedge clk);
    target_rate  = tgt[6:0];
    step         = stp[6:0];
    dwell_cycles = 16'(dw);
    hold_cycles  = 32'(hd);
    for (int t = 0; t <= fin + extra; t++) begin
      if (t > 0) @(negedge clk);
      start = (t == 0) || (start_hold && t <= fin);
      abort = (t == abort_at) || (t == a_dn);
      if (t == 1) begin
        // settings are captured at start; later changes must not matter
        target_rate  = 7'($urandom);
        step         = 7'($urandom);
        dwell_cycles = 16'($urandom);
        hold_cycles  = 32'($urandom);
      end
      @(posedge clk);
      #1;
      if (t > fin) begin
        er = 0;
      end else if (abort_at > 0 && t >= abort_at) begin
        k  = t - abort_at;
        er = r - (k / D) * S;
        if (er < 0) er = 0;
      end else begin
        er = norm_rate(t, T, S, D, H, U);
      end
      chk({tag, " rate"}, int'(TOGGLE_RATE), er);
      chk({tag, " busy"}, int'(busy), (t < fin) ? 1 : 0);
      chk({tag, " done"}, int'(done), (t == fin) ? 1 : 0);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    int   cyc, peak, a, tg, sp, dwv, hdv;
    bit   chain;

    tbl[0] = '{30, 10, 4, 5, 30, 29};
    tbl[1] = '{127, 60, 1, 1, 100, 5};
    tbl[2] = '{3, 0, 0, 2, 3, 8};
    tbl[3] = '{0, 5, 3, 4, 0, 4};
    tbl[4] = '{35, 10, 2, 3, 35, 19};
    tbl[5] = '{100, 100, 1, 0, 100, 3};
    tbl[6] = '{7, 3, 5, 1, 7, 31};
    tbl[7] = '{120, 0, 0, 0, 100, 201};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    target_rate = '0;
    step = '0;
    dwell_cycles = '0;
    hold_cycles = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset rate", int'(TOGGLE_RATE), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;

    // table: whole-run length and peak rate
    foreach (tbl[i]) begin
      @(negedge clk);
      target_rate  = tbl[i].tgt[6:0];
      step         = tbl[i].stp[6:0];
      dwell_cycles = 16'(tbl[i].dw);
      hold_cycles  = 32'(tbl[i].hd);
      start        = 1'b1;
      @(posedge clk);
      #1;
      cyc  = 0;
      peak = int'(TOGGLE_RATE);
      @(negedge clk);
      start = 1'b0;
      while (cyc < 1000) begin
        @(posedge clk);
        #1;
        cyc++;
        if (int'(TOGGLE_RATE) > peak) peak = int'(TOGGLE_RATE);
        if (done) break;
      end
      chk($sformatf("tbl%0d cycles", i), cyc, tbl[i].exp_cycles);
      chk($sformatf("tbl%0d peak", i), peak, tbl[i].exp_peak);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d done clears", i), int'(done), 0);
      chk($sformatf("tbl%0d idle", i), int'(busy), 0);
    end

    // reference ramp, cycle by cycle
    run_one(30, 10, 4, 5, 0, 1'b0, 1'b0, 2, "plan");
    // abort sampled at edge 25 while rate is 30 in UP
    run_one(50, 10, 8, 5, 25, 1'b0, 1'b0, 2, "abort_up");
    // abort while the rate is still 0 ends immediately
    run_one(50, 10, 8, 5, 3, 1'b0, 1'b0, 2, "abort_zero");
    // abort during DOWN is ignored
    run_one(30, 10, 4, 5, 0, 1'b1, 1'b0, 2, "abort_down");
    // start held high while busy does not restart
    run_one(20, 7, 2, 3, 0, 1'b0, 1'b1, 3, "start_hold");

    // start and abort together in IDLE stay idle
    @(negedge clk);
    target_rate = 7'd20;
    step = 7'd5;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("start+abort busy", int'(busy), 0);
    chk("start+abort rate", int'(TOGGLE_RATE), 0);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1;
    chk("start+abort still idle", int'(busy), 0);

    // start in the done cycle begins a new run
    run_one(10, 5, 2, 2, 0, 1'b0, 1'b0, 0, "chain_a");
    run_one(12, 4, 1, 3, 0, 1'b0, 1'b0, 2, "chain_b");

    // asynchronous reset in the middle of HOLD
    @(negedge clk);
    target_rate = 7'd70;
    step = 7'd70;
    dwell_cycles = 16'd1;
    hold_cycles = 32'd50;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset rate", int'(TOGGLE_RATE), 70);
    chk("pre-reset busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset rate", int'(TOGGLE_RATE), 0);
    chk("async reset busy", int'(busy), 0);
    chk("async reset done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset idle", int'(busy), 0);
    run_one(15, 5, 1, 2, 0, 1'b0, 1'b0, 2, "post_reset");

    // randomized runs
    for (int n = 0; n < 40; n++) begin
      tg  = $urandom_range(0, 127);
      sp  = (($urandom_range(0, 3)) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 127);
      dwv = $urandom_range(0, 3);
      hdv = $urandom_range(0, 6);
      a   = (($urandom_range(0, 2)) == 0) ? $urandom_range(1, 40) : 0;
      chain = ($urandom_range(0, 3) == 0);
      run_one(tg, sp, dwv, hdv, a, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              chain ? 0 : 2, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
